cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Parametrised blocking cache controller placed between the pipelined CPU's instruction or data port and the memory model. One instance is used per port.
- Produces the cacheStall signal that the CPU already consumes.
- Organisation is direct-mapped, write-through, no-write-allocate.
- A BYPASS mode sends every access straight to memory. This is the uncached configuration and keeps the same stall semantics.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- LINES, 4, number of cache lines; power of two, at least 2.
- BLOCK_WORDS, 4, words per line; power of two, at least 2.
- BYPASS, 0, 1 disables storage so every access goes to memory.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- c_readM  in  1  CPU read request, held while cacheStall=1.
- c_writeM  in  1  CPU write request, held while cacheStall=1.
- c_address  in  WORD_SIZE  CPU word address.
- c_wdata  in  WORD_SIZE  CPU write data.
- c_rdata  out  WORD_SIZE  CPU read data, valid when c_readM=1 and cacheStall=0.
- cacheStall  out  1  combinational; 1 tells the CPU to freeze and hold its request.
- m_readM  out  1  memory block-read request.
- m_writeM  out  1  memory single-word write request.
- m_address  out  WORD_SIZE  block-aligned address on reads, word address on writes.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  BLOCK_WORDS*WORD_SIZE  fill block; word 0 in the LSBs.
- m_ready  in  1  one-cycle pulse that completes the current memory request.
- hit_count  out  WORD_SIZE  read hits, wraps modulo 2^WORD_SIZE.
- miss_count  out  WORD_SIZE  read misses, wraps modulo 2^WORD_SIZE.

Behaviour:
- Address split: offset is the low log2(BLOCK_WORDS) bits, index the next log2(LINES) bits, tag the remainder.
- Reset (applies in any state, including mid-fill or mid-write):
  - state=IDLE, all valid bits=0, counters=0.
  - m_readM=0, m_writeM=0, m_address=0, m_wdata=0, c_rdata=0.
  - Tag and data arrays are not cleared.
- States: IDLE, FILL, RDONE, WRITE, WDONE.
- IDLE, read hit (valid, tag match, BYPASS=0):
  - c_rdata = stored word in the same cycle; cacheStall=0; hit_count+1.
  - Zero-cycle latency.
- IDLE, read miss (or any read when BYPASS=1):
  - cacheStall=1 combinationally; miss_count+1; next state FILL.
- FILL: m_readM=1, m_address=c_address with offset bits zeroed, cacheStall=1.
  - On m_ready: if BYPASS=0, write the whole line, set tag and valid.
  - Also on m_ready: latch the requested word into c_rdata; next state RDONE.
- RDONE: cacheStall=0, c_rdata holds the latched word; next state IDLE.
  - Read-miss penalty = memory latency + 1 cycle.
- IDLE, write: cacheStall=1; next state WRITE.
- WRITE: m_writeM=1, m_address=c_address, m_wdata=c_wdata, cacheStall=1.
  - On m_ready: if the line hits (BYPASS=0), update that word in the array; a miss allocates nothing. Next state WDONE.
- WDONE: cacheStall=0 for one cycle; next state IDLE.
- c_readM and c_writeM both high: the write takes priority and the read is ignored.
- m_ready in IDLE, RDONE or WDONE: ignored.
- No request in IDLE: cacheStall=0, no memory activity, counters unchanged.
- Memory outputs are registered by state. m_readM/m_writeM stay high until the cycle m_ready is sampled, then drop.
- Index aliasing: a fill overwrites the line unconditionally. Write-through means no dirty data is ever lost.

Decomposition:
- Shared package cache_pkg: state enum, and functions clog2-based OFFSET_W, INDEX_W, TAG_W derived from the parameters.
- Sub-module cache_array: valid, tag and data storage with a synchronous-reset valid vector, one line-write port and one word-write port. The combinational read port returns the hit flag and word.
- FSM and counters stay in cache_ctrl.

Test Plan (memory model asserts m_ready 4 cycles after a request, so the read-miss penalty is 5 cycles):
- Cold read 0x0012 -> FILL at m_address 0x0010, stall for 5 cycles, c_rdata = mem[0x0012], miss_count=1.
- Then read 0x0011 -> hit in the same cycle with no stall, c_rdata = mem[0x0011], hit_count=1.
- Write 0x0013 data 0xBEEF to a cached line -> m_writeM with data 0xBEEF, stall for 5 cycles; a following read of 0x0013 hits and returns 0xBEEF.
- Write 0x0040 to an uncached line -> memory updated, no fill; a following read of 0x0040 misses and miss_count increments.
- Conflict: read 0x0002 then 0x0012 (LINES=4, BLOCK_WORDS=4, same index) -> both miss; re-reading 0x0002 misses again.
- BYPASS=1: ten repeated reads of 0x0005 -> ten fills, hit_count=0, miss_count=10.
- Reset: assert Reset during FILL -> next cycle m_readM=0, state IDLE; a re-read of the previously cached address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache controller.
package cache_pkg;

  typedef enum logic [2:0] {StIdle, StFill, StRdone, StWrite, StWdone} state_e;

  function automatic int unsigned offset_w(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned word_size, input int unsigned lines,
                                        input int unsigned block_words);
    return word_size - $clog2(lines) - $clog2(block_words);
  endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: one whole-line write port, one single-word write port, async lookup.
module cache_array import cache_pkg::*; #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned LINES       = 4,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [WORD_SIZE-1:0]             addr,
  output logic                             hit,
  output logic [WORD_SIZE-1:0]             rdata,
  input  logic                             line_we,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] line_data,
  input  logic                             word_we,
  input  logic [WORD_SIZE-1:0]             word_data
);

  localparam int unsigned OffsetW = offset_w(BLOCK_WORDS);
  localparam int unsigned IndexW  = index_w(LINES);
  localparam int unsigned TagW    = tag_w(WORD_SIZE, LINES, BLOCK_WORDS);

  logic [LINES-1:0]     valid_q;
  logic [TagW-1:0]      tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES][BLOCK_WORDS];

  logic [OffsetW-1:0] offset;
  logic [IndexW-1:0]  index;
  logic [TagW-1:0]    tag;

  assign offset = addr[OffsetW-1:0];
  assign index  = addr[OffsetW +: IndexW];
  assign tag    = addr[WORD_SIZE-1 -: TagW];

  assign hit   = valid_q[index] && (tag_q[index] == tag);
  assign rdata = data_q[index][offset];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data are deliberately left out of reset; valid alone guards them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index] <= tag;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        data_q[index][w] <= line_data[w*WORD_SIZE +: WORD_SIZE];
      end
    end else if (word_we) begin
      data_q[index][offset] <= word_data;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Blocking direct-mapped, write-through, no-write-allocate cache controller with hit/miss
// counters; BYPASS=1 turns every access into a memory access with identical stall timing.
module cache_ctrl import cache_pkg::*; #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned LINES       = 4,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned BYPASS      = 0
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             c_readM,
  input  logic                             c_writeM,
  input  logic [WORD_SIZE-1:0]             c_address,
  input  logic [WORD_SIZE-1:0]             c_wdata,
  output logic [WORD_SIZE-1:0]             c_rdata,
  output logic                             cacheStall,
  output logic                             m_readM,
  output logic                             m_writeM,
  output logic [WORD_SIZE-1:0]             m_address,
  output logic [WORD_SIZE-1:0]             m_wdata,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] m_rdata,
  input  logic                             m_ready,
  output logic [WORD_SIZE-1:0]             hit_count,
  output logic [WORD_SIZE-1:0]             miss_count
);

  localparam int unsigned OffsetW = offset_w(BLOCK_WORDS);

  state_e               state_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 arr_hit_raw;
  logic                 hit;
  logic [WORD_SIZE-1:0] arr_word;
  logic [WORD_SIZE-1:0] fill_word;
  logic [OffsetW-1:0]   offset;
  logic                 line_we;
  logic                 word_we;
  logic                 idle_read_hit;

  assign offset        = c_address[OffsetW-1:0];
  assign hit           = arr_hit_raw && (BYPASS == 0);
  assign fill_word     = m_rdata[offset*WORD_SIZE +: WORD_SIZE];
  assign line_we       = (state_q == StFill) && m_ready && (BYPASS == 0);
  assign word_we       = (state_q == StWrite) && m_ready && hit;
  assign idle_read_hit = (state_q == StIdle) && c_readM && !c_writeM && hit;

  cache_array #(
    .WORD_SIZE  (WORD_SIZE),
    .LINES      (LINES),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_array (
    .clk       (Clk),
    .reset     (Reset),
    .addr      (c_address),
    .hit       (arr_hit_raw),
    .rdata     (arr_word),
    .line_we   (line_we),
    .line_data (m_rdata),
    .word_we   (word_we),
    .word_data (c_wdata)
  );

  always_comb begin
    cacheStall = 1'b0;
    unique case (state_q)
      StIdle:           cacheStall = c_writeM || (c_readM && !hit);
      StFill, StWrite:  cacheStall = 1'b1;
      default:          cacheStall = 1'b0;
    endcase
  end

  // Hits bypass the latch so read hits complete with zero added latency.
  assign c_rdata = idle_read_hit ? arr_word : rdata_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      m_readM    <= 1'b0;
      m_writeM   <= 1'b0;
      m_address  <= '0;
      m_wdata    <= '0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (c_writeM) begin
            m_writeM  <= 1'b1;
            m_address <= c_address;
            m_wdata   <= c_wdata;
            state_q   <= StWrite;
          end else if (c_readM) begin
            if (hit) begin
              hit_count <= hit_count + 1'b1;
            end else begin
              miss_count <= miss_count + 1'b1;
              m_readM    <= 1'b1;
              m_address  <= {c_address[WORD_SIZE-1:OffsetW], {OffsetW{1'b0}}};
              state_q    <= StFill;
            end
          end
        end
        StFill: begin
          if (m_ready) begin
            m_readM <= 1'b0;
            rdata_q <= fill_word;
            state_q <= StRdone;
          end
        end
        StWrite: begin
          if (m_ready) begin
            m_writeM <= 1'b0;
            state_q  <= StWdone;
          end
        end
        StRdone, StWdone: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench: a cached instance and a BYPASS instance share a 256-word memory model
// that answers every request with m_ready four cycles after the request cycle.
module tb_cache_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        rd     [2];
  logic        wr     [2];
  logic [15:0] addr   [2];
  logic [15:0] wdata  [2];
  logic [15:0] rdata  [2];
  logic        stall  [2];
  logic        mrd    [2];
  logic        mwr    [2];
  logic [15:0] maddr  [2];
  logic [15:0] mwdata [2];
  logic [15:0] hitc   [2];
  logic [15:0] missc  [2];
  logic [63:0] mrdata0, mrdata1;
  logic        mrdy0, mrdy1;
  int          cnt0, cnt1;
  logic        mem_init;

  logic [15:0] mem [256];
  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 Clk = ~Clk;

  cache_ctrl #(.WORD_SIZE(16), .LINES(4), .BLOCK_WORDS(4), .BYPASS(0)) dut (
    .Clk(Clk), .Reset(Reset), .c_readM(rd[0]), .c_writeM(wr[0]), .c_address(addr[0]),
    .c_wdata(wdata[0]), .c_rdata(rdata[0]), .cacheStall(stall[0]), .m_readM(mrd[0]),
    .m_writeM(mwr[0]), .m_address(maddr[0]), .m_wdata(mwdata[0]), .m_rdata(mrdata0),
    .m_ready(mrdy0), .hit_count(hitc[0]), .miss_count(missc[0])
  );

  cache_ctrl #(.WORD_SIZE(16), .LINES(4), .BLOCK_WORDS(4), .BYPASS(1)) dut_bypass (
    .Clk(Clk), .Reset(Reset), .c_readM(rd[1]), .c_writeM(wr[1]), .c_address(addr[1]),
    .c_wdata(wdata[1]), .c_rdata(rdata[1]), .cacheStall(stall[1]), .m_readM(mrd[1]),
    .m_writeM(mwr[1]), .m_address(maddr[1]), .m_wdata(mwdata[1]), .m_rdata(mrdata1),
    .m_ready(mrdy1), .hit_count(hitc[1]), .miss_count(missc[1])
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return ({8'h00, a} * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return init_val(a[7:0]);
  endfunction

  // Memory for the cached instance; also the only writer of mem.
  always @(posedge Clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i[7:0]);
      mem_init <= 1'b1;
    end
    if (Reset) begin
      mrdy0 <= 1'b0;
      cnt0  <= 0;
    end else if ((mrd[0] || mwr[0]) && !mrdy0) begin
      if (cnt0 == 2) begin
        mrdy0   <= 1'b1;
        cnt0    <= 0;
        mrdata0 <= {mem[maddr[0][7:0] + 8'd3], mem[maddr[0][7:0] + 8'd2],
                    mem[maddr[0][7:0] + 8'd1], mem[maddr[0][7:0]]};
      end else begin
        cnt0 <= cnt0 + 1;
      end
    end else begin
      if (mrdy0 && mwr[0]) mem[maddr[0][7:0]] <= mwdata[0];
      mrdy0 <= 1'b0;
    end
  end

  always @(posedge Clk) begin
    if (Reset) begin
      mrdy1 <= 1'b0;
      cnt1  <= 0;
    end else if ((mrd[1] || mwr[1]) && !mrdy1) begin
      if (cnt1 == 2) begin
        mrdy1   <= 1'b1;
        cnt1    <= 0;
        mrdata1 <= {mem[maddr[1][7:0] + 8'd3], mem[maddr[1][7:0] + 8'd2],
                    mem[maddr[1][7:0] + 8'd1], mem[maddr[1][7:0]]};
      end else begin
        cnt1 <= cnt1 + 1;
      end
    end else begin
      mrdy1 <= 1'b0;
    end
  end

  // Starts and ends just after a rising edge.
  task automatic cpu_read(input int sel, input logic [15:0] a, input int exp_stalls,
                          input string nm);
    int          stalls = 0;
    logic        saw_fill = 1'b0;
    logic [15:0] exp;
    rd[sel]   = 1'b1;
    addr[sel] = a;
    exp_q.push_back(model_rd(a));
    @(negedge Clk);
    while (stall[sel] === 1'b1 && stalls < 50) begin
      if (mrd[sel] === 1'b1 && !saw_fill) begin
        saw_fill = 1'b1;
        n_checks++;
        if (maddr[sel] !== (a & 16'hFFFC)) begin
          n_fail++;
          $display("FAIL %s fill address: got %h expected %h", nm, maddr[sel], a & 16'hFFFC);
        end
      end
      stalls++;
      @(negedge Clk);
    end
    n_checks++;
    if (stalls !== exp_stalls) begin
      n_fail++;
      $display("FAIL %s stall cycles: got %0d expected %0d", nm, stalls, exp_stalls);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (rdata[sel] !== exp) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", nm, rdata[sel], exp);
    end
    @(posedge Clk);
    #1;
    rd[sel] = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input string nm);
    int   stalls = 0;
    logic saw_wr = 1'b0;
    logic saw_rd = 1'b0;
    wr[0]    = 1'b1;
    addr[0]  = a;
    wdata[0] = d;
    model[int'(a)] = d;
    @(negedge Clk);
    while (stall[0] === 1'b1 && stalls < 50) begin
      if (mrd[0] === 1'b1) saw_rd = 1'b1;
      if (mwr[0] === 1'b1 && !saw_wr) begin
        saw_wr = 1'b1;
        n_checks++;
        if (maddr[0] !== a || mwdata[0] !== d) begin
          n_fail++;
          $display("FAIL %s write bus: got %h/%h expected %h/%h", nm, maddr[0], mwdata[0], a, d);
        end
      end
      stalls++;
      @(negedge Clk);
    end
    n_checks++;
    if (stalls !== 5 || !saw_wr || saw_rd) begin
      n_fail++;
      $display("FAIL %s write handshake: stalls %0d wr %0b rd %0b expected 5 1 0",
               nm, stalls, saw_wr, saw_rd);
    end
    @(posedge Clk);
    #1;
    wr[0] = 1'b0;
  endtask

  task automatic check_counts(input int sel, input logic [15:0] eh, input logic [15:0] em,
                              input string nm);
    n_checks++;
    if (hitc[sel] !== eh || missc[sel] !== em) begin
      n_fail++;
      $display("FAIL %s counters: got hit %0d miss %0d expected hit %0d miss %0d",
               nm, hitc[sel], missc[sel], eh, em);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (stall[s] !== 1'b0 || mrd[s] !== 1'b0 || mwr[s] !== 1'b0 || maddr[s] !== 16'h0 ||
          mwdata[s] !== 16'h0 || rdata[s] !== 16'h0 || hitc[s] !== 16'h0 || missc[s] !== 16'h0)
      begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got stall %b rd %b wr %b addr %h wd %h rdata %h h %0d m %0d expected all zero",
                 s, stall[s], mrd[s], mwr[s], maddr[s], mwdata[s], rdata[s], hitc[s], missc[s]);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_read_miss_hit();
    cpu_read(0, 16'h0012, 5, "cold_miss_0012");
    check_counts(0, 16'd0, 16'd1, "after_cold_miss");
    cpu_read(0, 16'h0011, 0, "hit_0011");
    check_counts(0, 16'd1, 16'd1, "after_hit");
  endtask

  task automatic test_write_hit();
    cpu_write(16'h0013, 16'hBEEF, "write_hit_0013");
    cpu_read(0, 16'h0013, 0, "read_after_write_hit");
    check_counts(0, 16'd2, 16'd1, "after_write_hit");
  endtask

  task automatic test_write_miss();
    cpu_write(16'h0040, 16'h1234, "write_miss_0040");
    n_checks++;
    if (mem[8'h40] !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_miss_mem: got %h expected %h", mem[8'h40], 16'h1234);
    end
    cpu_read(0, 16'h0040, 5, "read_after_write_miss");
    check_counts(0, 16'd2, 16'd2, "after_write_miss");
  endtask

  task automatic test_conflict();
    cpu_read(0, 16'h0002, 5, "conflict_0002");
    cpu_read(0, 16'h0012, 5, "conflict_0012");
    cpu_read(0, 16'h0002, 5, "conflict_0002_again");
    check_counts(0, 16'd2, 16'd5, "after_conflict");
  endtask

  task automatic test_back_to_back();
    cpu_read(0, 16'h0024, 5, "b2b_miss_0024");
    cpu_read(0, 16'h0025, 0, "b2b_hit_0025");
    cpu_read(0, 16'h0027, 0, "b2b_hit_0027");
    check_counts(0, 16'd4, 16'd6, "after_b2b");
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 10; i++) cpu_read(1, 16'h0005, 5, "bypass_0005");
    check_counts(1, 16'd0, 16'd10, "after_bypass");
  endtask

  task automatic test_reset_mid_fill();
    rd[0]   = 1'b1;
    addr[0] = 16'h0038;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (mrd[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_before_reset m_readM: got %b expected 1", mrd[0]);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    rd[0] = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (mrd[0] !== 1'b0 || stall[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got m_readM %b stall %b expected 0 0", mrd[0], stall[0]);
    end
    check_counts(0, 16'd0, 16'd0, "counts_after_mid_reset");
    @(posedge Clk);
    #1;
    cpu_read(0, 16'h0024, 5, "reread_after_reset");
    check_counts(0, 16'd0, 16'd1, "after_reread");
  endtask

  initial begin
    mem_init = 1'b0;
    Reset    = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd[s]    = 1'b0;
      wr[s]    = 1'b0;
      addr[s]  = 16'h0;
      wdata[s] = 16'h0;
    end
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_back_to_back();
    test_bypass();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
